// File: rtl/gpr_file.sv
// General-purpose register file with two read ports, one write port
// and a pending-write scoreboard for in-order issue hazard tracking.
module gpr_file #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_enable,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic                rsv_enable,
  input  logic [ADDR_W-1:0]   rsv_addr,
  input  logic [ADDR_W-1:0]   r_addr_a,
  input  logic [ADDR_W-1:0]   r_addr_b,
  output logic [DATA_W-1:0]   r_data_a,
  output logic [DATA_W-1:0]   r_data_b,
  output logic                busy_a,
  output logic                busy_b,
  output logic [NUM_REGS-1:0] pending
);

  localparam logic [NUM_REGS-1:0] HW =
    (ZERO_R0 != 0) ? NUM_REGS'(1) : '0;

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [DATA_W-1:0]   mem_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic [NUM_REGS-1:0] wsel;
  logic [NUM_REGS-1:0] rsel;

  logic [ADDR_W-1:0]   raddr [2];
  logic [DATA_W-1:0]   rdata [2];
  logic [1:0]          rbusy;
  logic [1:0]          fwd;

  assign raddr[0] = r_addr_a;
  assign raddr[1] = r_addr_b;

  // One-hot decode; addresses past NUM_REGS match nothing.
  always_comb begin
    wsel = '0;
    rsel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wsel[i] = w_enable &&
                (w_addr == ADDR_W'(i)) && !HW[i];
      rsel[i] = rsv_enable &&
                (rsv_addr == ADDR_W'(i)) && !HW[i];
    end
  end

  // Next state: a reserve beats a same-cycle write-back.
  always_comb begin
    pend_d = (pend_q & ~wsel) | rsel;
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = wsel[i] ? w_data : mem_q[i];
    end
  end

  // Storage and scoreboard, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
      pend_q <= pend_d;
    end
  end

  // Read ports with optional forwarding; outputs held low in reset.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      rbusy[p] = 1'b0;
      fwd[p]   = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (raddr[p] == ADDR_W'(i)) begin
          rdata[p] = mem_q[i];
          rbusy[p] = pend_q[i];
          fwd[p]   = (BYPASS != 0) && wsel[i];
        end
      end
      if (fwd[p]) begin
        rdata[p] = w_data;
        rbusy[p] = 1'b0;
      end
      if (!rst) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end
    end
  end

  assign r_data_a = rdata[0];
  assign r_data_b = rdata[1];
  assign busy_a   = rbusy[0];
  assign busy_b   = rbusy[1];
  assign pending  = pend_q;

endmodule
